// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
// State encoding and parity mode constants.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: ticks on the last clk of each serial bit.
// Counter is held at zero while the line is not in a frame.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic run,
  output logic bit_tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (res || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it
// as a UART frame (start, data LSB first, parity, stop).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic HAS_PAR = (PARITY_EN != 0);
  localparam logic ODD     = (PARITY_ODD == PAR_ODD);

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sr;
  logic             par;
  logic             run;
  logic             bit_tick;
  logic             fetch;

  assign run = (state == S_START) || (state == S_DATA) ||
               (state == S_PARITY) || (state == S_STOP);
  assign fetch      = tx_enable && !fifo_empty;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_STOP) && bit_tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .res     (res),
    .run     (run),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (fetch) begin
            state      <= S_REQ;
            fifo_rd_en <= 1'b1;
          end
        end
        S_REQ: state <= S_LOAD;
        S_LOAD: begin
          sr      <= fifo_rdata;
          par     <= (^fifo_rdata) ^ ODD;
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= S_START;
        end
        // sr always holds the not-yet-sent bits in its LSBs
        S_START: if (bit_tick) begin
          tx    <= sr[0];
          sr    <= sr >> 1;
          state <= S_DATA;
        end
        S_DATA: if (bit_tick) begin
          if (bit_cnt == LAST_BIT) begin
            state <= HAS_PAR ? S_PARITY : S_STOP;
            tx    <= HAS_PAR ? par : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx      <= sr[0];
            sr      <= sr >> 1;
          end
        end
        S_PARITY: if (bit_tick) begin
          state <= S_STOP;
          tx    <= 1'b1;
        end
        S_STOP: if (bit_tick) begin
          if (fetch) begin
            state      <= S_REQ;
            fifo_rd_en <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even,
// odd) each fed by a behavioural FIFO; frames decoded per bit.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic       tx_en [3];
  logic       empty [3];
  logic [7:0] rdata [3] = '{default: '0};
  logic       rd_en [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  logic [7:0] mem   [3][64];
  logic [5:0] wp    [3] = '{default: '0};
  logic [5:0] rp    [3] = '{default: '0};
  int         pops  [3] = '{default: 0};
  int         pushed[3] = '{default: 0};
  logic       uflow [3] = '{default: 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : gd
    fifo_uart_tx #(
      .WIDTH       (8),
      .CLKS_PER_BIT(16),
      .PARITY_EN   ((g > 0) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0)
    ) dut (
      .clk       (clk),
      .res       (res),
      .tx_enable (tx_en[g]),
      .fifo_empty(empty[g]),
      .fifo_rdata(rdata[g]),
      .fifo_rd_en(rd_en[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .frame_done(done[g])
    );
  end

  always_comb begin
    for (int g = 0; g < 3; g++) empty[g] = (wp[g] == rp[g]);
  end

  // FIFO model: rdata valid the cycle after a pop
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_en[g] === 1'b1) begin
        pops[g] <= pops[g] + 1;
        if (empty[g]) begin
          uflow[g] <= 1'b1;
        end else begin
          rdata[g] <= mem[g][rp[g]];
          rp[g]    <= rp[g] + 6'd1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] w);
    mem[g][wp[g]] = w;
    wp[g] = wp[g] + 6'd1;
    pushed[g]++;
  endtask

  function automatic logic model_par(input logic [7:0] w,
                                     input bit odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // Expected line level in bit slot b of a frame
  function automatic logic exp_bit(input logic [7:0] w,
                                   input bit pen,
                                   input logic p,
                                   input int b);
    logic [7:0] v;
    v = w;
    if (b == 0) return 1'b0;
    if (b <= 8) return v[b-1];
    if (pen && b == 9) return p;
    return 1'b1;
  endfunction

  task automatic wait_pop(input int g, input int budget,
                          input string nm, output bit ok);
    int n = 0;
    while (rd_en[g] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_pop"}, 32'(rd_en[g]), 32'd1);
    ok = (rd_en[g] === 1'b1);
  endtask

  // Starts at a negedge; returns at the last STOP cycle
  task automatic run_frame(input int g, input logic [7:0] w,
                           input logic p, input int budget,
                           input string nm);
    bit ok;
    bit pen;
    int len;
    int berr = 0;
    int derr = 0;
    int bzerr = 0;
    pen = (g > 0);
    len = (pen ? 11 : 10) * 16;
    wait_pop(g, budget, nm, ok);
    if (!ok) return;
    @(negedge clk);
    chk({nm, "_load_tx"}, 32'(tx[g]), 32'd1);
    chk({nm, "_load_rd"}, 32'(rd_en[g]), 32'd0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (tx[g] !== exp_bit(w, pen, p, k / 16)) berr++;
      if (done[g] !== 1'((k == len - 1))) derr++;
      if (busy[g] !== 1'b1) bzerr++;
    end
    chk({nm, "_bits"}, 32'(berr), 32'd0);
    chk({nm, "_done"}, 32'(derr), 32'd0);
    chk({nm, "_busy"}, 32'(bzerr), 32'd0);
  endtask

  typedef struct {
    int         g;
    logic [7:0] w;
    logic       p;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    int p0;
    int err;
    int g;
    logic [7:0] w;

    tbl[0] = '{0, 8'hA5, 1'b0};
    tbl[1] = '{1, 8'h07, 1'b1};
    tbl[2] = '{2, 8'h07, 1'b0};
    tbl[3] = '{1, 8'h00, 1'b0};
    tbl[4] = '{2, 8'h00, 1'b1};
    tbl[5] = '{1, 8'hFF, 1'b0};
    tbl[6] = '{0, 8'h80, 1'b0};

    res = 1'b1;
    for (int i = 0; i < 3; i++) tx_en[i] = 1'b1;
    push(0, 8'h3C);

    repeat (2) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx[0]), 32'd1);
      chk("rst_rd", 32'(rd_en[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
    end
    chk("rst_nopop", 32'(pops[0]), 32'd0);
    res = 1'b0;
    run_frame(0, 8'h3C, 1'b0, 4, "post_rst");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      push(tbl[i].g, tbl[i].w);
      run_frame(tbl[i].g, tbl[i].w, tbl[i].p, 4,
                $sformatf("vec%0d", i));
    end

    // back-to-back: REQ and LOAD are the only gap cycles
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    run_frame(0, 8'h00, 1'b0, 4, "b2b0");
    run_frame(0, 8'hFF, 1'b0, 1, "b2b1");
    run_frame(0, 8'h55, 1'b0, 1, "b2b2");
    repeat (2) @(negedge clk);
    chk("b2b_empty", 32'(empty[0]), 32'd1);
    chk("b2b_idle", 32'(busy[0]), 32'd0);
    chk("b2b_uflow", 32'(uflow[0]), 32'd0);

    // gating
    tx_en[0] = 1'b0;
    push(0, 8'h12);
    push(0, 8'h34);
    p0 = pops[0];
    err = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) err++;
    end
    chk("gate_idle", 32'(err), 32'd0);
    chk("gate_nopop", 32'(pops[0] - p0), 32'd0);
    tx_en[0] = 1'b1;
    fork
      run_frame(0, 8'h12, 1'b0, 4, "gate_w1");
      begin
        repeat (80) @(negedge clk);
        tx_en[0] = 1'b0;
      end
    join
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) err++;
    end
    chk("gate_stop_idle", 32'(err), 32'd0);
    chk("gate_one_pop", 32'(pops[0] - p0), 32'd1);
    chk("gate_left", 32'(empty[0]), 32'd0);
    tx_en[0] = 1'b1;
    run_frame(0, 8'h34, 1'b0, 4, "gate_w2");

    // reset in the middle of data bit 3
    @(negedge clk);
    push(0, 8'h96);
    push(0, 8'hC3);
    wait_pop(0, 4, "rstmid", ok);
    repeat (1 + 16 + 48 + 4) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", 32'(tx[0]), 32'd1);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_done", 32'(done[0]), 32'd0);
    res = 1'b0;
    run_frame(0, 8'hC3, 1'b0, 1, "rstmid_next");

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = int'($urandom_range(2, 0));
      w = 8'($urandom);
      push(g, w);
      run_frame(g, w, model_par(w, g == 2), 4,
                $sformatf("rnd%0d", i));
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pops%0d", i), 32'(pops[i]),
          32'(pushed[i]));
      chk($sformatf("uflow%0d", i), 32'(uflow[i]), 32'd0);
      chk($sformatf("idle_tx%0d", i), 32'(tx[i]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
